// File: rtl/xbar_resp_core.sv
// Response crossbar: four bank response ports routed to three channel ports
// by the one-hot channel id each bank echoes, with round-robin arbitration
// and a two-entry output FIFO per channel.
module xbar_resp_core #(
   parameter int DATA_W     = 64,
   parameter int OP_W       = 2,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              u_bank_0_resp_valid,
   output logic              u_bank_0_resp_ready,
   input  logic [2:0]        u_bank_0_resp_ch_1hot_id,
   input  logic [OP_W-1:0]   u_bank_0_resp_op,
   input  logic [DATA_W-1:0] u_bank_0_resp_rdata,
   input  logic              u_bank_1_resp_valid,
   output logic              u_bank_1_resp_ready,
   input  logic [2:0]        u_bank_1_resp_ch_1hot_id,
   input  logic [OP_W-1:0]   u_bank_1_resp_op,
   input  logic [DATA_W-1:0] u_bank_1_resp_rdata,
   input  logic              u_bank_2_resp_valid,
   output logic              u_bank_2_resp_ready,
   input  logic [2:0]        u_bank_2_resp_ch_1hot_id,
   input  logic [OP_W-1:0]   u_bank_2_resp_op,
   input  logic [DATA_W-1:0] u_bank_2_resp_rdata,
   input  logic              u_bank_3_resp_valid,
   output logic              u_bank_3_resp_ready,
   input  logic [2:0]        u_bank_3_resp_ch_1hot_id,
   input  logic [OP_W-1:0]   u_bank_3_resp_op,
   input  logic [DATA_W-1:0] u_bank_3_resp_rdata,
   output logic              d_channel_0_resp_valid,
   input  logic              d_channel_0_resp_ready,
   output logic [OP_W-1:0]   d_channel_0_resp_op,
   output logic [DATA_W-1:0] d_channel_0_resp_rdata,
   output logic [1:0]        d_channel_0_resp_bank_id,
   output logic              d_channel_1_resp_valid,
   input  logic              d_channel_1_resp_ready,
   output logic [OP_W-1:0]   d_channel_1_resp_op,
   output logic [DATA_W-1:0] d_channel_1_resp_rdata,
   output logic [1:0]        d_channel_1_resp_bank_id,
   output logic              d_channel_2_resp_valid,
   input  logic              d_channel_2_resp_ready,
   output logic [OP_W-1:0]   d_channel_2_resp_op,
   output logic [DATA_W-1:0] d_channel_2_resp_rdata,
   output logic [1:0]        d_channel_2_resp_bank_id,
   output logic              resp_err
);

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] rdata;
      logic [1:0]        bank;
   } ent_t;

   localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

   logic [3:0] b_vld;
   logic [3:0] b_rdy;
   logic [3:0] legal;
   logic [2:0] b_id [4];
   ent_t       b_ent [4];

   logic [2:0] c_rdy;
   logic [2:0] push_ok;
   logic [2:0] gnt;
   logic [2:0] pop;
   logic [1:0] gidx [3];
   logic [1:0] cnt_d [3];
   logic       err_d;

   ent_t       mem_q [3][2];
   logic [2:0] wp_q;
   logic [2:0] rp_q;
   logic [1:0] cnt_q [3];
   logic [1:0] rr_q [3];
   logic       err_q;
   ent_t       head [3];

   assign b_vld = {u_bank_3_resp_valid, u_bank_2_resp_valid,
                   u_bank_1_resp_valid, u_bank_0_resp_valid};
   assign b_id[0] = u_bank_0_resp_ch_1hot_id;
   assign b_id[1] = u_bank_1_resp_ch_1hot_id;
   assign b_id[2] = u_bank_2_resp_ch_1hot_id;
   assign b_id[3] = u_bank_3_resp_ch_1hot_id;
   assign b_ent[0] = '{u_bank_0_resp_op, u_bank_0_resp_rdata, 2'd0};
   assign b_ent[1] = '{u_bank_1_resp_op, u_bank_1_resp_rdata, 2'd1};
   assign b_ent[2] = '{u_bank_2_resp_op, u_bank_2_resp_rdata, 2'd2};
   assign b_ent[3] = '{u_bank_3_resp_op, u_bank_3_resp_rdata, 2'd3};
   assign c_rdy = {d_channel_2_resp_ready, d_channel_1_resp_ready,
                   d_channel_0_resp_ready};

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         legal[k] = (b_id[k] == 3'b001) || (b_id[k] == 3'b010) ||
                    (b_id[k] == 3'b100);
      end
   end

   // Scan from the lowest priority upward so the highest-priority
   // requester is the last one to claim the grant.
   always_comb begin
      logic [1:0] kk;
      kk = '0;
      for (int j = 0; j < 3; j++) begin
         gnt[j]     = 1'b0;
         gidx[j]    = '0;
         pop[j]     = (cnt_q[j] != 2'd0) && c_rdy[j];
         push_ok[j] = (cnt_q[j] < FULL) ||
                      ((cnt_q[j] == FULL) && c_rdy[j]);
         for (int i = 3; i >= 0; i--) begin
            kk = rr_q[j] + 2'(i);
            if (b_vld[kk] && legal[kk] && b_id[kk][j]) begin
               gnt[j]  = 1'b1;
               gidx[j] = kk;
            end
         end
         gnt[j]   = gnt[j] && push_ok[j] && rst_n;
         cnt_d[j] = cnt_q[j] + 2'(gnt[j]) - 2'(pop[j]);
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         b_rdy[k] = b_vld[k] && !legal[k];
         for (int j = 0; j < 3; j++) begin
            if (gnt[j] && (gidx[j] == 2'(k))) b_rdy[k] = 1'b1;
         end
         b_rdy[k] = b_rdy[k] && rst_n;
      end
      err_d = err_q || (|(b_vld & ~legal));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 3; j++) begin
            for (int e = 0; e < 2; e++) mem_q[j][e] <= '0;
            cnt_q[j] <= '0;
            rr_q[j]  <= '0;
         end
         wp_q  <= '0;
         rp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         for (int j = 0; j < 3; j++) begin
            if (gnt[j]) begin
               mem_q[j][wp_q[j]] <= b_ent[gidx[j]];
               wp_q[j]           <= ~wp_q[j];
               rr_q[j]           <= gidx[j] + 2'd1;
            end
            if (pop[j]) rp_q[j] <= ~rp_q[j];
            cnt_q[j] <= cnt_d[j];
         end
         err_q <= err_d;
      end
   end

   always_comb begin
      for (int j = 0; j < 3; j++) head[j] = mem_q[j][rp_q[j]];
   end

   assign u_bank_0_resp_ready = b_rdy[0];
   assign u_bank_1_resp_ready = b_rdy[1];
   assign u_bank_2_resp_ready = b_rdy[2];
   assign u_bank_3_resp_ready = b_rdy[3];

   assign d_channel_0_resp_valid   = cnt_q[0] != 2'd0;
   assign d_channel_0_resp_op      = head[0].op;
   assign d_channel_0_resp_rdata   = head[0].rdata;
   assign d_channel_0_resp_bank_id = head[0].bank;
   assign d_channel_1_resp_valid   = cnt_q[1] != 2'd0;
   assign d_channel_1_resp_op      = head[1].op;
   assign d_channel_1_resp_rdata   = head[1].rdata;
   assign d_channel_1_resp_bank_id = head[1].bank;
   assign d_channel_2_resp_valid   = cnt_q[2] != 2'd0;
   assign d_channel_2_resp_op      = head[2].op;
   assign d_channel_2_resp_rdata   = head[2].rdata;
   assign d_channel_2_resp_bank_id = head[2].bank;

   assign resp_err = err_q;

endmodule

// File: tb/tb_xbar_resp_core.sv
// Scoreboard bench for xbar_resp_core: a behavioural model predicts bank
// accepts and queues expected payloads; a monitor checks channel outputs.
module tb_xbar_resp_core;

   logic        clk;
   logic        rst_n;
   logic        bv   [4];
   logic        brdy [4];
   logic [2:0]  bid  [4];
   logic [1:0]  bop  [4];
   logic [63:0] bdat [4];
   logic        cv   [3];
   logic        cr   [3];
   logic [1:0]  cop  [3];
   logic [63:0] cdat [3];
   logic [1:0]  cbid [3];
   logic        resp_err;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] d;
      logic [1:0]  b;
   } exp_t;

   exp_t q [3][$];
   int   m_rr  [3];
   int   m_cnt [3];
   bit   m_err;
   bit   chk_en;
   int   errors;
   int   checks;

   xbar_resp_core dut (
      .clk(clk), .rst_n(rst_n),
      .u_bank_0_resp_valid(bv[0]), .u_bank_0_resp_ready(brdy[0]),
      .u_bank_0_resp_ch_1hot_id(bid[0]), .u_bank_0_resp_op(bop[0]),
      .u_bank_0_resp_rdata(bdat[0]),
      .u_bank_1_resp_valid(bv[1]), .u_bank_1_resp_ready(brdy[1]),
      .u_bank_1_resp_ch_1hot_id(bid[1]), .u_bank_1_resp_op(bop[1]),
      .u_bank_1_resp_rdata(bdat[1]),
      .u_bank_2_resp_valid(bv[2]), .u_bank_2_resp_ready(brdy[2]),
      .u_bank_2_resp_ch_1hot_id(bid[2]), .u_bank_2_resp_op(bop[2]),
      .u_bank_2_resp_rdata(bdat[2]),
      .u_bank_3_resp_valid(bv[3]), .u_bank_3_resp_ready(brdy[3]),
      .u_bank_3_resp_ch_1hot_id(bid[3]), .u_bank_3_resp_op(bop[3]),
      .u_bank_3_resp_rdata(bdat[3]),
      .d_channel_0_resp_valid(cv[0]), .d_channel_0_resp_ready(cr[0]),
      .d_channel_0_resp_op(cop[0]), .d_channel_0_resp_rdata(cdat[0]),
      .d_channel_0_resp_bank_id(cbid[0]),
      .d_channel_1_resp_valid(cv[1]), .d_channel_1_resp_ready(cr[1]),
      .d_channel_1_resp_op(cop[1]), .d_channel_1_resp_rdata(cdat[1]),
      .d_channel_1_resp_bank_id(cbid[1]),
      .d_channel_2_resp_valid(cv[2]), .d_channel_2_resp_ready(cr[2]),
      .d_channel_2_resp_op(cop[2]), .d_channel_2_resp_rdata(cdat[2]),
      .d_channel_2_resp_bank_id(cbid[2]),
      .resp_err(resp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Reference model: legal ids have exactly one bit set; each channel
   // serves the first requesting bank at or after its pointer, mod 4,
   // when its two-slot queue has room or is popping while full.
   always @(negedge clk) begin
      if (chk_en) begin
         bit   erdy [4];
         bit   popj, okj;
         int   g, k;
         exp_t e;
         #1;
         chk("resp_err", resp_err, m_err);
         for (int b = 0; b < 4; b++) begin
            erdy[b] = 1'b0;
            if (bv[b] && $countones(bid[b]) != 1) begin
               erdy[b] = 1'b1;
               m_err   = 1'b1;
            end
         end
         for (int j = 0; j < 3; j++) begin
            popj = (m_cnt[j] != 0) && cr[j];
            okj  = (m_cnt[j] < 2) || (m_cnt[j] == 2 && cr[j]);
            g = -1;
            for (int i = 0; i < 4; i++) begin
               k = (m_rr[j] + i) % 4;
               if (g < 0 && bv[k] && $countones(bid[k]) == 1 && bid[k][j])
                  g = k;
            end
            if (g >= 0 && okj) begin
               erdy[g] = 1'b1;
               e.op = bop[g];
               e.d  = bdat[g];
               e.b  = 2'(g);
               q[j].push_back(e);
               m_rr[j] = (g + 1) % 4;
               m_cnt[j]++;
            end
            if (popj) m_cnt[j]--;
         end
         for (int b = 0; b < 4; b++)
            chk($sformatf("bank%0d_ready", b), brdy[b], erdy[b]);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         for (int j = 0; j < 3; j++) begin
            chk($sformatf("ch%0d_valid", j), cv[j], q[j].size() != 0);
            if (cv[j] && cr[j]) begin
               if (q[j].size() == 0) begin
                  chk($sformatf("ch%0d_unexpected", j), 1, 0);
               end else begin
                  e = q[j].pop_front();
                  chk($sformatf("ch%0d_op", j), cop[j], e.op);
                  chk($sformatf("ch%0d_rdata", j), cdat[j], e.d);
                  chk($sformatf("ch%0d_bank_id", j), cbid[j], e.b);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int b = 0; b < 4; b++) bv[b] = 1'b0;
   endtask

   task automatic drive(input int b, input logic [2:0] id,
                        input logic [1:0] op, input logic [63:0] d);
      bv[b]   = 1'b1;
      bid[b]  = id;
      bop[b]  = op;
      bdat[b] = d;
   endtask

   task automatic set_rdy(input logic r0, input logic r1, input logic r2);
      cr[0] = r0;
      cr[1] = r1;
      cr[2] = r2;
   endtask

   task automatic model_reset();
      for (int j = 0; j < 3; j++) begin
         q[j].delete();
         m_rr[j]  = 0;
         m_cnt[j] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("%s_ch%0d_valid", tag, j), cv[j], 0);
         chk($sformatf("%s_ch%0d_payload", tag, j),
             {cop[j], cdat[j], cbid[j]} != 0, 0);
      end
      for (int b = 0; b < 4; b++)
         chk($sformatf("%s_bank%0d_ready", tag, b), brdy[b], 0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      chk_en = 1'b0;
      model_reset();
      for (int b = 0; b < 4; b++) begin
         bv[b] = 1'b0; bid[b] = '0; bop[b] = '0; bdat[b] = '0;
      end
      set_rdy(1, 1, 1);
      rst_n = 1'b0;
      drive(3, 3'b000, 0, 64'h1);
      drive(0, 3'b001, 1, 64'h2);
      repeat (2) tick();
      check_reset_outputs("rst");
      chk("rst_resp_err", resp_err, 0);
      idle();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      drive(2, 3'b010, 2'd1, 64'hA5A5);
      tick();
      idle();
      repeat (3) tick();

      for (int c = 0; c < 8; c++) begin
         for (int b = 0; b < 4; b++)
            drive(b, 3'b001, 2'(b), 64'h100 + 64'(c * 4 + b));
         tick();
      end
      idle();
      repeat (3) tick();

      set_rdy(1, 1, 0);
      for (int c = 0; c < 5; c++) begin
         drive(1, 3'b100, 2'(c), 64'h200 + 64'(c));
         tick();
      end
      idle();
      repeat (2) tick();
      set_rdy(1, 1, 1);
      repeat (4) tick();

      set_rdy(0, 1, 1);
      for (int c = 0; c < 3; c++) begin
         drive(0, 3'b001, 2'(c), 64'h300 + 64'(c));
         tick();
      end
      set_rdy(1, 1, 1);
      for (int c = 0; c < 3; c++) begin
         drive(0, 3'b001, 2'(c), 64'h310 + 64'(c));
         tick();
      end
      idle();
      repeat (3) tick();

      drive(0, 3'b100, 2'd3, 64'h400);
      drive(3, 3'b001, 2'd2, 64'h403);
      drive(1, 3'b010, 2'd1, 64'h401);
      tick();
      idle();
      repeat (3) tick();

      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 9) < 6)
               drive(b, 3'(1 << $urandom_range(0, 2)),
                     2'($urandom), {$urandom, $urandom});
            else
               bv[b] = 1'b0;
         end
         set_rdy($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 7);
         tick();
      end
      idle();
      set_rdy(1, 1, 1);
      repeat (4) tick();

      drive(3, 3'b000, 2'd1, 64'h500);
      tick();
      idle();
      repeat (3) tick();
      drive(3, 3'b011, 2'd2, 64'h501);
      tick();
      idle();
      repeat (3) tick();

      set_rdy(0, 0, 1);
      for (int c = 0; c < 3; c++) begin
         drive(0, 3'b001, 2'(c), 64'h600 + 64'(c));
         drive(1, 3'b010, 2'(c), 64'h610 + 64'(c));
         tick();
      end
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_reset_outputs("midrst");
      chk("midrst_resp_err", resp_err, 0);
      model_reset();
      tick();
      idle();
      set_rdy(1, 1, 1);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      for (int c = 0; c < 6; c++) begin
         for (int b = 0; b < 4; b++)
            drive(b, 3'b001, 2'(b), 64'h700 + 64'(c * 4 + b));
         tick();
      end
      idle();
      repeat (5) tick();

      chk_en = 1'b0;
      for (int j = 0; j < 3; j++)
         chk($sformatf("ch%0d_drained", j), q[j].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xbar_resp_core.md
Name: xbar_resp_core

Overview:
Response-direction crossbar of the memory-parallel cache. It returns bank responses to the requesting channels, using the channel_1hot_id that each bank echoes back. There are 4 bank response inputs and 3 channel response outputs. Each channel has its own round-robin arbiter and a 2-entry output FIFO.

Parameters:
DATA_W, 64, width of response read data
OP_W, 2, width of echoed op field
FIFO_DEPTH, 2, entries per channel output FIFO (fixed at 2; other values are unsupported)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
u_bank_k_resp_valid  in  1  bank k response valid (k=0..3)
u_bank_k_resp_ready  out  1  bank k response accepted this cycle
u_bank_k_resp_ch_1hot_id  in  3  target channel, one-hot
u_bank_k_resp_op  in  OP_W  echoed op
u_bank_k_resp_rdata  in  DATA_W  read data
d_channel_j_resp_valid  out  1  channel j response valid (j=0..2)
d_channel_j_resp_ready  in  1  channel j accepts
d_channel_j_resp_op  out  OP_W  op
d_channel_j_resp_rdata  out  DATA_W  data
d_channel_j_resp_bank_id  out  2  source bank index
resp_err  out  1  sticky: a response with an illegal channel id was seen

Behaviour:
- Decode per bank:
  - Target is the single set bit of ch_1hot_id.
  - Zero-hot or multi-hot id is illegal: u_bank_k_resp_ready=1 in the same cycle, the response is dropped (pushed nowhere), and resp_err is set.
  - resp_err clears only on reset.
- Per-channel arbitration:
  - Requesters are banks with valid=1 whose legal target is j.
  - Priority is round-robin. Pointer rr_j is 2 bits and resets to 0, so bank rr_j has highest priority, then rr_j+1, and so on, mod 4.
  - After a grant to bank k, rr_j becomes (k+1) mod 4. rr_j is unchanged when there is no grant.
  - At most one grant per channel per cycle. Different channels grant independently in the same cycle.
  - A bank targets only one channel, so each bank has at most one grant.
- Grant and push:
  - The grant fires only if push_ok_j = (count_j < 2) || (count_j == 2 && d_channel_j_resp_valid && d_channel_j_resp_ready).
  - u_bank_k_resp_ready = grant. It is combinational from valid and state. Banks must not wait for ready before asserting valid.
  - Push writes {op, rdata, bank index} into FIFO j.
- FIFO:
  - 2 entries, with 1-bit wr/rd pointers and a 2-bit count. Pointers wrap 1 -> 0.
  - d_channel_j_resp_valid = (count_j != 0). Outputs are driven from the head entry register.
  - Latency: accepted at edge N, visible on channel outputs after edge N (one cycle).
  - Simultaneous push and pop: count unchanged. Simultaneous push and pop when full is legal (see push_ok_j).
  - Push when empty: the entry appears the next cycle. There is no combinational bypass.
  - Output payload is held stable while valid=1 and ready=0.
- Ordering: responses from one bank to one channel are delivered in acceptance order. No ordering is guaranteed across banks.
- Reset values (asynchronous, all state):
  - Counts 0, pointers 0, rr 0, resp_err 0.
  - All d_channel_j_resp_valid 0; payload outputs 0 (storage cleared).
  - All u_bank_k_resp_ready 0 while rst_n=0.
- Reset mid-operation: buffered responses are discarded. Upstream must also reset.
- No deadlock: a channel with ready tied to 1 sustains 1 response per cycle.

Test Plan:
- Single path: bank 2 sends op=1, rdata=0xA5A5, id=3'b010 with channel 1 ready=1 -> bank 2 ready=1 that cycle; next cycle channel 1 valid=1, rdata=0xA5A5, bank_id=2; other channels stay idle.
- Contention: banks 0..3 all target channel 0 continuously, ready=1 -> grants in order 0,1,2,3,0; one delivery per cycle.
- Backpressure: channel 2 ready=0 and bank 1 streams to it -> exactly 2 accepts, then bank 1 ready=0. Release ready -> data delivered in order, stable while stalled, no loss or duplication.
- Full plus simultaneous pop: FIFO j full with ready=1 and a new request -> accepted the same cycle, count stays 2.
- Parallel routing: bank 0 -> channel 2, bank 3 -> channel 0, bank 1 -> channel 1, all in the same cycle -> all three accepted in that cycle and all delivered next cycle.
- Illegal id: bank 3 sends id=3'b000, later id=3'b011 -> accepted and dropped each time, no channel valid, resp_err=1 until rst_n=0.
- Reset mid-stream: assert rst_n=0 with both FIFOs full -> all valids 0 immediately (asynchronous); after release, FIFOs are empty and rr=0.
